// File: rtl/tt_um_dff_mem_burst_if.sv
// Byte-wide pin bundle for the flip-flop memory block: op/data inputs from the
// host side, read data and status back.
interface tt_um_dff_mem_burst_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_dff_mem_burst.sv
// Small flip-flop memory with address register, autoincrement and a CLEAR fill
// engine. Optional per-entry even parity is enabled with macro DFF_MEM_PARITY_EN.
module tt_um_dff_mem_burst #(
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tt_um_dff_mem_burst_if.slave   bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    localparam logic [2:0] OP_SET   = 3'b001;
    localparam logic [2:0] OP_WRITE = 3'b010;
    localparam logic [2:0] OP_READ  = 3'b011;
    localparam logic [2:0] OP_CLEAR = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_fill_idx;
    logic [7:0]         r_fill_val;
    logic [7:0]         r_uo;
    logic               r_rd_valid;
    logic               r_wrap;

    logic               w_busy;
    logic               w_accept;
    logic [2:0]         w_op;
    logic               w_autoinc;
    logic               w_do_set;
    logic               w_do_write;
    logic               w_do_read;
    logic               w_do_clear;
    logic               w_fill_step;
    logic               w_fill_last;
    logic               w_step_addr;

    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [7:0]         w_wdata;
    logic [7:0]         w_mem [DEPTH];
    logic [7:0]         w_rdata;
    logic               w_parity_err;
    logic               w_unused_bits;

    // Ops are only decoded when selected and the fill engine is not running.
    assign w_busy      = (r_state == ST_FILL);
    assign w_accept    = bus.ena & ~w_busy;
    assign w_op        = bus.uio_in[2:0];
    assign w_autoinc   = bus.uio_in[3];
    assign w_do_set    = w_accept && (w_op == OP_SET);
    assign w_do_write  = w_accept && (w_op == OP_WRITE);
    assign w_do_read   = w_accept && (w_op == OP_READ);
    assign w_do_clear  = w_accept && (w_op == OP_CLEAR);
    assign w_fill_step = w_busy & bus.ena;
    assign w_fill_last = w_fill_step && (r_fill_idx == LAST_IDX);
    assign w_step_addr = (w_do_write || w_do_read) && w_autoinc;

    assign w_unused_bits = &{1'b0, bus.uio_in[7:4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_do_clear)  w_state_next = ST_FILL;
            ST_FILL: if (w_fill_last) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Single write port shared by the fill engine and host WRITE ops.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_addr;
        w_wdata = bus.ui_in;
        if (w_fill_step) begin
            w_we    = 1'b1;
            w_waddr = r_fill_idx;
            w_wdata = r_fill_val;
        end else if (w_do_write) begin
            w_we    = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [7:0] r_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= 8'h00;
                end else if (w_we && (w_waddr == ADDR_W'(gi))) begin
                    r_data <= w_wdata;
                end
            end

            assign w_mem[gi] = r_data;
        end
    endgenerate

    assign w_rdata = w_mem[r_addr];

`ifdef DFF_MEM_PARITY_EN
    logic w_par [DEPTH];
    logic r_parity_err;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_parity
            logic r_par;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_par <= 1'b0;
                end else if (w_we && (w_waddr == ADDR_W'(gi))) begin
                    r_par <= ^w_wdata;
                end
            end

            assign w_par[gi] = r_par;
        end
    endgenerate

    // Stored bit makes data+parity even; any disagreement on READ is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else if (w_do_read && ((^w_rdata) != w_par[r_addr])) begin
            r_parity_err <= 1'b1;
        end
    end

    assign w_parity_err = r_parity_err;
`else
    assign w_parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_fill_idx <= '0;
            r_fill_val <= 8'h00;
            r_uo       <= 8'h00;
            r_rd_valid <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_rd_valid <= w_do_read;

            if (w_do_read) begin
                r_uo <= w_rdata;
            end

            if (w_do_clear) begin
                r_fill_val <= bus.ui_in;
                r_fill_idx <= '0;
            end else if (w_fill_step) begin
                r_fill_idx <= r_fill_idx + 1'b1;
            end

            if (w_fill_last) begin
                r_addr <= '0;
            end else if (w_do_set) begin
                r_addr <= bus.ui_in[ADDR_W-1:0];
            end else if (w_step_addr) begin
                r_addr <= r_addr + 1'b1;
            end

            if (w_do_set) begin
                r_wrap <= 1'b0;
            end else if (w_step_addr && (r_addr == LAST_IDX)) begin
                r_wrap <= 1'b1;
            end
        end
    end

    assign bus.uo_out  = r_uo;
    assign bus.uio_out = {w_busy, r_rd_valid, r_wrap, w_parity_err, 4'b0000};
    assign bus.uio_oe  = 8'hF0;

endmodule

// File: doc/tt_um_dff_mem_burst.md
TT_UM_DFF_MEM_BURST -- requirements
Module: tt_um_dff_mem_burst

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, giving address width; DEPTH = 2^ADDR_W entries of 8 bits; legal range 2..6.
REQ-002 clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ena  input  1  design select; when 0, ops SHALL be ignored, and an in-flight CLEAR SHALL pause and hold state.
REQ-005 ui_in  input  8  data byte for WRITE/CLEAR; address on ui_in[ADDR_W-1:0] for SET_ADDR.
REQ-006 uo_out  output  8  read-data register.
REQ-007 uio_in  input  8  [2:0] op code, [3] autoinc enable; [7:4] ignored.
REQ-008 uio_out  output  8  [7] busy, [6] rd_valid, [5] wrap (sticky), [4] parity_err (sticky); [3:0] = 0.
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 Op sampled each rising edge with ena=1 and busy=0: 000 NOP, 001 SET_ADDR, 010 WRITE, 011 READ, 100 CLEAR, 101-111 NOP.
REQ-011 SET_ADDR SHALL load addr <= ui_in[ADDR_W-1:0] and clear wrap in the same edge.
REQ-012 WRITE SHALL store mem[addr] <= ui_in at that edge.
REQ-013 READ SHALL load uo_out <= mem[addr] at that edge; rd_valid SHALL be 1 for exactly the following cycle, else 0.
REQ-014 WRITE/READ with uio_in[3]=1 SHALL post-increment addr modulo DEPTH; on DEPTH-1 -> 0, wrap SHALL set.
REQ-015 READ of the address just written by the immediately preceding op SHALL return the new data (no bypass needed; write completes first).
REQ-016 CLEAR SHALL capture ui_in as fill value, set busy next cycle, write fill to entries 0..DEPTH-1 one per ena=1 cycle, then drop busy and set addr=0.
REQ-017 CLEAR on DEPTH=16 SHALL hold busy for exactly 16 ena=1 cycles; the op after the last fill write SHALL be accepted.
REQ-018 Ops presented while busy=1 SHALL be dropped, no side effects.
REQ-019 FSM SHALL have states IDLE and FILL only; IDLE->FILL on accepted CLEAR, FILL->IDLE after fill index DEPTH-1 written.
REQ-020 uo_out SHALL change only on READ or reset.

Reset
REQ-021 rst_n=0 SHALL asynchronously force: all mem entries 0, addr 0, uo_out 8'h00, busy/rd_valid/wrap/parity_err 0, FSM IDLE.
REQ-022 Reset during FILL SHALL abort fill; all entries 0 after release regardless of fill progress.
REQ-023 First op SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-024 With DFF_MEM_PARITY_EN defined, each entry SHALL store an even-parity bit written by WRITE/CLEAR; a READ with mismatch SHALL set parity_err (sticky until reset).
REQ-025 Without DFF_MEM_PARITY_EN, no parity storage SHALL exist and uio_out[4] SHALL be constant 0.

Verification
REQ-026 Reset, SET_ADDR 3, WRITE 8'hA5, SET_ADDR 3, READ -> uo_out=8'hA5, rd_valid one cycle, uio_oe=8'hF0.
REQ-027 SET_ADDR 14, autoinc WRITE 8'h11,8'h22,8'h33 -> entries 14,15,0 hold 11,22,33; wrap=1; SET_ADDR 0 -> wrap=0.
REQ-028 CLEAR fill 8'h5A, then READ op held every cycle -> busy=1 for 16 cycles, READs dropped, first accepted READ of entry 0 returns 8'h5A.
REQ-029 CLEAR fill 8'hFF, assert rst_n=0 at fill cycle 7 -> all outputs 0; autoinc READ of all 16 entries returns 8'h00.
REQ-030 WRITE with ena=0 then READ -> entry unchanged; ena dropped mid-CLEAR for 4 cycles -> busy extends by 4 cycles.
REQ-031 Both macro builds: 64 random autoinc WRITE/READ pairs -> data matches model, parity_err stays 0.
